// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and single-port memory side.
// master = requesters + memory model, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_ready;
    logic [DATA_W-1:0]     if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [DATA_W/8-1:0]   dm_wstrb;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_ready;
    logic [DATA_W-1:0]     dm_rdata;

    logic                  mem_en;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata, mem_en, mem_wstrb, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata, mem_en, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one single-port synchronous memory, latency 1.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default gives the data port priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               original_clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;

    logic                r_if_out;
    logic                r_dm_out;
    logic                r_last_grant;

    logic                w_if_elig;
    logic                w_dm_elig;
    logic                w_grant_if;
    logic                w_grant_dm;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [STRB_W-1:0]   w_mem_wstrb;

    // Gating with rst keeps the memory strobe quiet while reset is held.
    assign w_if_elig = rst & bus.if_req & ~r_if_out;
    assign w_dm_elig = rst & bus.dm_req & ~r_dm_out;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_grant_dm = w_dm_elig & (~w_if_elig | ~r_last_grant);
    assign w_grant_if = w_if_elig & ~w_grant_dm;
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
    assign w_grant_dm = w_dm_elig;
    assign w_grant_if = w_if_elig & ~w_dm_elig;
`endif

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_wstrb = '0;
        if (w_grant_dm) begin
            w_mem_addr  = bus.dm_addr;
            w_mem_wdata = bus.dm_wdata;
            w_mem_wstrb = bus.dm_we ? bus.dm_wstrb : '0;
        end else if (w_grant_if) begin
            w_mem_addr  = bus.if_addr;
        end
    end

    assign bus.mem_en    = w_grant_if | w_grant_dm;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_wstrb = w_mem_wstrb;

    // Outstanding flag doubles as the ready pulse: the memory answers one cycle after issue.
    always_ff @(posedge original_clk or negedge rst) begin
        if (!rst) begin
            r_if_out     <= 1'b0;
            r_dm_out     <= 1'b0;
            r_last_grant <= 1'b0;
        end else begin
            r_if_out <= w_grant_if;
            r_dm_out <= w_grant_dm;
            if (w_grant_if | w_grant_dm)
                r_last_grant <= w_grant_dm;
        end
    end

    assign bus.if_ready = r_if_out;
    assign bus.dm_ready = r_dm_out;
    assign bus.if_rdata = r_if_out ? bus.mem_rdata : '0;
    assign bus.dm_rdata = r_dm_out ? bus.mem_rdata : '0;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width for both requesters and the memory.
REQ-002 SHALL have parameter DATA_W, default 32: data width; DATA_W/8 byte strobes.
REQ-003 SHALL have port original_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  input  1  fetch request; held high by the fetch stage until if_ready.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port if_ready  output  1  one-cycle pulse: fetch completed; if_rdata valid.
REQ-008 SHALL have port if_rdata  output  DATA_W  fetch read data.
REQ-009 SHALL have port dm_req  input  1  data access request; held high until dm_ready.
REQ-010 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port dm_wstrb  input  DATA_W/8  store byte enables.
REQ-012 SHALL have port dm_addr  input  ADDR_W  data address.
REQ-013 SHALL have port dm_wdata  input  DATA_W  store data.
REQ-014 SHALL have port dm_ready  output  1  one-cycle pulse: access completed; dm_rdata valid for loads.
REQ-015 SHALL have port dm_rdata  output  DATA_W  load data.
REQ-016 SHALL have port mem_en  output  1  single-port synchronous memory access strobe.
REQ-017 SHALL have port mem_wstrb  output  DATA_W/8  memory byte write enables; all zero = read.
REQ-018 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-019 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-020 SHALL have port mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en.

Function
REQ-021 SHALL issue at most one memory access per cycle, combinationally from current requests and state.
REQ-022 SHALL track per-port outstanding flags if_out and dm_out, set on issue and cleared the next cycle.
REQ-023 SHALL treat a port as eligible only when its req is high and its outstanding flag is clear.
REQ-024 SHALL, when exactly one port is eligible, grant it; when none, drive mem_en=0, mem_wstrb=0.
REQ-025 SHALL, on a data grant, drive mem_addr=dm_addr, mem_wdata=dm_wdata, mem_wstrb=dm_we?dm_wstrb:0.
REQ-026 SHALL, on a fetch grant, drive mem_addr=if_addr, mem_wstrb=0, mem_wdata=0.
REQ-027 SHALL assert the granted port's ready exactly one cycle after issue (latency 1), for loads and stores alike.
REQ-028 SHALL drive if_rdata and dm_rdata from mem_rdata while the respective ready is high, and zero otherwise.
REQ-029 SHALL allow an issue to one port in the same cycle as the other port's ready (back-to-back, 100% memory utilisation).
REQ-030 SHALL give a single port at most one access every two cycles (re-eligible the cycle after its ready).
REQ-031 SHALL never assert if_ready and dm_ready in the same cycle.
REQ-032 SHALL ignore dm_wstrb/dm_wdata when dm_we=0; a store with dm_wstrb=0 still completes with dm_ready.
REQ-033 SHALL keep a last_grant register (0 = fetch, 1 = data) updated on every issue.

Reset
REQ-034 SHALL, while rst=0, force if_out=0, dm_out=0, last_grant=0, if_ready=0, dm_ready=0, mem_en=0, mem_wstrb=0.
REQ-035 SHALL drop any transaction in flight when reset asserts mid-operation; no ready pulse for it after release.
REQ-036 SHALL accept a new request in the first rising edge after rst returns high.

Configuration
REQ-037 SHALL, with macro ARB_ROUND_ROBIN_EN defined, resolve simultaneous eligibility by granting the port not equal to last_grant.
REQ-038 SHALL, without ARB_ROUND_ROBIN_EN, resolve simultaneous eligibility by always granting the data port.

Verification
REQ-039 SHALL cover: if_req=1 alone, if_addr=0x10, mem_rdata=0x00A00093 -> mem_en cycle N, if_ready and if_rdata=0x00A00093 cycle N+1, next issue N+2.
REQ-040 SHALL cover: dm store dm_addr=0x200, dm_wdata=0xDEADBEEF, dm_wstrb=0xF -> mem_wstrb=0xF, mem_addr=0x200 cycle N; dm_ready N+1.
REQ-041 SHALL cover: both held high continuously, no macro -> data granted on every eligible cycle, fetch only in cycles when dm_out=1.
REQ-042 SHALL cover: both held high, ARB_ROUND_ROBIN_EN -> grants alternate IF/DM every cycle; mem_en=1 every cycle; readies alternate.
REQ-043 SHALL cover: rst low the cycle after a fetch issue -> no if_ready pulse; all outputs 0; first request after release issues next edge.
REQ-044 SHALL cover: load dm_we=0, dm_wstrb=0xF -> mem_wstrb=0; dm_rdata equals mem_rdata during dm_ready, 0 otherwise.
